// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK_WAIT
    } rx_state_t;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous bit; resets to the idle-high level.
module uart_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// Oversampling UART receiver: start-bit validation, mid-bit sampling, stop check,
// and a single-entry valid/ready output register with frame-error and overrun pulses.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 os_tick,
    input  logic                 rx_line,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 sline;
    rx_state_t            state, state_n;
    logic [TW-1:0]        tick_cnt, tick_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 deliver;
    logic                 ferr_n;
    logic                 drop;

    uart_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_line),
        .q     (sline)
    );

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        deliver = 1'b0;
        ferr_n  = 1'b0;
        if (os_tick) begin
            unique case (state)
                IDLE: begin
                    if (!sline) begin
                        state_n = START;
                        tick_n  = '0;
                    end
                end
                START: begin
                    if (tick_cnt == HALF_LAST) begin
                        if (sline) begin
                            state_n = IDLE;
                        end else begin
                            state_n = DATA;
                            tick_n  = '0;
                            bit_n   = '0;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == FULL_LAST) begin
                        tick_n  = '0;
                        shreg_n = {sline, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            state_n = STOP;
                            bit_n   = '0;
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt == FULL_LAST) begin
                        tick_n = '0;
                        if (sline) begin
                            deliver = 1'b1;
                            state_n = IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = BRK_WAIT;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                BRK_WAIT: begin
                    if (sline) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // A byte arriving into a full register that is not being drained is lost.
    assign drop = deliver && rx_valid && !rx_ready;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_n;
            bit_cnt   <= bit_n;
            shreg     <= shreg_n;
            frame_err <= ferr_n;
            overrun   <= drop;
            if (deliver && !drop) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser with a frame-offset reference model and per-cycle compare.
module tb_uart_rx_deser;

    localparam int OS   = 16;
    localparam int DB   = 8;
    localparam int HALF = OS / 2;
    localparam int BITC = 4 * OS;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       os_tick = 1'b0;
    logic       rx_line = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_rx_deser #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .os_tick   (os_tick),
        .rx_line   (rx_line),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // os_tick every 4th clk, updated shortly after the edge
    initial begin
        int tcnt;
        tcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            tcnt = (tcnt + 1) % 4;
            os_tick = (tcnt == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Reference model: frames are timed by os_tick offsets from the detected start.
    logic [7:0] m_data  = '0;
    logic       m_valid = 1'b0;
    logic       m_ferr  = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_busy  = 1'b0;
    logic       stop_next = 1'b0;

    initial begin
        logic s1, s2, sl, old_valid;
        int   mode, off, k;
        logic [7:0] acc;
        s1 = 1'b1; s2 = 1'b1; mode = 0; off = 0; acc = '0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                s1 = 1'b1; s2 = 1'b1; mode = 0; off = 0; acc = '0;
                m_data = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
            end else begin
                sl = s2;
                s2 = s1;
                s1 = rx_line;
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
                old_valid = m_valid;
                if (m_valid && rx_ready) m_valid = 1'b0;
                if (os_tick) begin
                    case (mode)
                        0: if (!sl) begin mode = 1; off = 0; acc = '0; end
                        1: begin
                            off++;
                            if (off == HALF) begin
                                if (sl) mode = 0;
                            end else if (off > HALF && (off - HALF) % OS == 0) begin
                                k = (off - HALF) / OS;
                                if (k <= DB) begin
                                    if (sl) acc = acc + 8'(1 << (k - 1));
                                end else if (sl) begin
                                    mode = 0;
                                    if (old_valid && !rx_ready) m_ovr = 1'b1;
                                    else begin m_data = acc; m_valid = 1'b1; end
                                end else begin
                                    mode = 2;
                                    m_ferr = 1'b1;
                                end
                            end
                        end
                        default: if (sl) mode = 0;
                    endcase
                end
            end
            m_busy = (mode != 0);
            stop_next = (mode == 1) && (off == HALF + OS * (DB + 1) - 1);
        end
    end

    // Per-cycle compare plus event counters used by the directed checks
    int vcnt = 0, xfers = 0, ferr_cnt = 0, ovr_cnt = 0, busy_cnt = 0;
    logic [7:0] last_data = '0;
    logic prev_valid = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            chk("rx_valid", 32'(rx_valid), 32'(m_valid));
            chk("rx_data", 32'(rx_data), 32'(m_data));
            chk("frame_err", 32'(frame_err), 32'(m_ferr));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("busy", 32'(busy), 32'(m_busy));
            if (rx_valid && !prev_valid) begin vcnt++; last_data = rx_data; end
            prev_valid = rx_valid;
            if (rx_valid && rx_ready) xfers++;
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (busy) busy_cnt++;
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_line = 1'b0;
        step(BITC);
        for (int unsigned i = 0; i < 8; i++) begin
            rx_line = b[i];
            step(BITC);
        end
        rx_line = stop_bit;
        step(BITC);
    endtask

    initial begin
        int v0, x0, f0, o0;
        bit hit;
        step(3);
        chk("reset_valid", 32'(rx_valid), 0);
        chk("reset_data", 32'(rx_data), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_flags", 32'({frame_err, overrun}), 0);
        reset = 1'b0;
        step(20);

        // single good frame
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1);
        step(BITC);
        chk("a5_pulses", 32'(vcnt), 1);
        chk("a5_data", 32'(last_data), 32'h A5);
        chk("a5_model", 32'(m_data), 32'h A5);
        chk("a5_flags", 32'(ferr_cnt + ovr_cnt), 0);
        chk("a5_busy", 32'(busy), 0);

        // short start glitch
        busy_cnt = 0;
        rx_line = 1'b0;
        step(12);
        rx_line = 1'b1;
        step(100);
        chk("glitch_valid", 32'(vcnt), 1);
        chk("glitch_busy_win", 32'(busy_cnt >= 1 && busy_cnt <= 40), 1);
        chk("glitch_idle", 32'(busy), 0);

        // framing error then recovery
        send_frame(8'h3C, 1'b0);
        rx_line = 1'b1;
        step(BITC);
        chk("ferr_pulses", 32'(ferr_cnt), 1);
        chk("ferr_valid", 32'(vcnt), 1);
        send_frame(8'h11, 1'b1);
        step(BITC);
        chk("after_ferr_data", 32'(last_data), 32'h11);
        chk("after_ferr_cnt", 32'(vcnt), 2);

        // overrun: two bytes with no consumer
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        step(BITC);
        chk("ovr_valid", 32'(rx_valid), 1);
        chk("ovr_held", 32'(rx_data), 32'h01);
        chk("ovr_pulse", 32'(ovr_cnt - o0), 1);
        x0 = xfers;
        rx_ready = 1'b1;
        step(3);
        chk("ovr_drain_valid", 32'(rx_valid), 0);
        chk("ovr_drain_xfers", 32'(xfers - x0), 1);

        // ready arrives on the same edge as the next delivery
        rx_ready = 1'b0;
        send_frame(8'h33, 1'b1);
        chk("sim_first", 32'(rx_data), 32'h33);
        o0 = ovr_cnt;
        x0 = xfers;
        hit = 1'b0;
        fork
            send_frame(8'h55, 1'b1);
            begin
                for (int i = 0; i < 2000 && !hit; i++) begin
                    if (stop_next && os_tick) begin
                        hit = 1'b1;
                        rx_ready = 1'b1;
                        step(1);
                        rx_ready = 1'b0;
                    end else begin
                        step(1);
                    end
                end
            end
        join
        chk("sim_edge_found", 32'(hit), 1);
        chk("sim_data", 32'(rx_data), 32'h55);
        chk("sim_valid", 32'(rx_valid), 1);
        chk("sim_no_ovr", 32'(ovr_cnt - o0), 0);
        chk("sim_xfer", 32'(xfers - x0), 1);
        rx_ready = 1'b1;
        step(4);

        // reset in the middle of a frame
        v0 = vcnt;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                step(3 * BITC);
                chk("mid_busy", 32'(busy), 1);
                reset = 1'b1;
                #1;
                chk("rst_valid", 32'(rx_valid), 0);
                chk("rst_data", 32'(rx_data), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_flags", 32'({frame_err, overrun}), 0);
                step(3);
                reset = 1'b0;
            end
        join
        chk("rst_no_byte", 32'(vcnt - v0), 0);
        step(BITC);
        send_frame(8'h80, 1'b1);
        step(BITC);
        chk("post_rst_data", 32'(last_data), 32'h80);
        chk("post_rst_cnt", 32'(vcnt - v0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
